// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester, multiplier and response signals around the shared multiplier.
// The arbiter connects through the slave modport; the requesters and multiplier side use master.
interface mult_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [31:0]         mul_a;
    logic [31:0]         mul_b;
    logic [63:0]         mul_res;
    logic [N_REQ-1:0]    rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_data;
    logic                busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_res,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_res,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined 32x32->64 multiplier among N_REQ requesters.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no pointer register).
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    mult_share_arbiter_if.slave  bus
);

    function automatic logic [N_REQ-1:0] id_decode(input logic [ID_W-1:0] id, input logic vld);
        logic [N_REQ-1:0] res;
        res = '0;
        if (vld) begin
            res[id] = 1'b1;
        end else begin
            res = '0;
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] lane_idx(input logic [ID_W-1:0] start, input int k);
        return ID_W'((int'(start) + k) % N_REQ);
    endfunction

    logic [ID_W-1:0]  ptr_s;
    logic             hit_s;
    logic [ID_W-1:0]  grant_id_s;
    logic             xfer_s;
    logic [31:0]      sel_a_s;
    logic [31:0]      sel_b_s;
    logic [31:0]      mul_a_r;
    logic [31:0]      mul_b_r;
    logic [MUL_LAT:0] tag_vld_r;
    logic [ID_W-1:0]  tag_id_r [0:MUL_LAT];

`ifdef MULT_ARB_FIXED_PRIO_EN
    assign ptr_s = '0;
`else
    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] next_ptr_s;

    assign next_ptr_s = ID_W'((int'(grant_id_s) + 1) % N_REQ);

    // Round-robin pointer: one past the most recently granted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (xfer_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`endif

    // Pick the first valid requester at or after the search start, wrapping.
    always_comb begin
        hit_s      = 1'b0;
        grant_id_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit_s && bus.req_valid[lane_idx(ptr_s, k)]) begin
                hit_s      = 1'b1;
                grant_id_s = lane_idx(ptr_s, k);
            end else begin
                hit_s      = hit_s;
                grant_id_s = grant_id_s;
            end
        end
    end

    // Flush and reset both veto the grant within the same cycle.
    assign xfer_s        = hit_s && !flush && !reset;
    assign bus.req_ready = id_decode(grant_id_s, xfer_s);

    assign sel_a_s = bus.req_a[32*int'(grant_id_s) +: 32];
    assign sel_b_s = bus.req_b[32*int'(grant_id_s) +: 32];

    // Operand registers feeding the multiplier; hold when nothing transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a_r <= 32'd0;
            mul_b_r <= 32'd0;
        end else if (xfer_s) begin
            mul_a_r <= sel_a_s;
            mul_b_r <= sel_b_s;
        end else begin
            mul_a_r <= mul_a_r;
            mul_b_r <= mul_b_r;
        end
    end

    assign bus.mul_a = mul_a_r;
    assign bus.mul_b = mul_b_r;

    // Tag pipeline tracking requester ids alongside the multiplier stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_r <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_id_r[k] <= '0;
            end
        end else begin
            if (flush) begin
                tag_vld_r <= '0;
            end else begin
                tag_vld_r <= {tag_vld_r[MUL_LAT-1:0], xfer_s};
            end
            tag_id_r[0] <= grant_id_s;
            for (int k = 1; k <= MUL_LAT; k++) begin
                tag_id_r[k] <= tag_id_r[k-1];
            end
        end
    end

    assign bus.rsp_valid = id_decode(tag_id_r[MUL_LAT], tag_vld_r[MUL_LAT]);
    assign bus.rsp_id    = tag_vld_r[MUL_LAT] ? tag_id_r[MUL_LAT] : '0;
    assign bus.rsp_data  = bus.mul_res;
    assign bus.busy      = |tag_vld_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: vector table, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_mult_share_arbiter;
    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 2;

    logic clk;
    logic reset;
    logic flush;

    mult_share_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    mult_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage multiplier stand-in.
    logic [63:0] prod1;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            prod1       <= 64'd0;
            bus.mul_res <= 64'd0;
        end else begin
            prod1       <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
            bus.mul_res <= prod1;
        end
    end

    typedef struct {
        int          e;
        int          id;
        logic [63:0] d;
    } exp_t;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] exp_rdy;
    } vec_t;

    exp_t        q[$];
    int          mp;
    int          cyc;
    int          n_chk;
    int          n_err;
    logic [31:0] opa [4];
    logic [31:0] opb [4];
    logic [31:0] exp_ma;
    logic [31:0] exp_mb;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic int model_grant(input logic [3:0] vld);
        int r;
        r = -1;
        if (!reset && !flush) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            for (int i = 3; i >= 0; i--) if (vld[i]) r = i;
`else
            for (int k = 3; k >= 0; k--) if (vld[(mp + k) % 4]) r = (mp + k) % 4;
`endif
        end
        return r;
    endfunction

    task automatic model_check();
        int          g;
        logic [3:0]  er;
        logic [3:0]  erv;
        logic [1:0]  eid;
        logic [63:0] ed;
        g  = model_grant(bus.req_valid);
        er = (g < 0) ? 4'b0000 : 4'(1 << g);
        while (q.size() > 0 && q[0].e + MUL_LAT < cyc) q.delete(0);
        erv = 4'b0000;
        eid = 2'd0;
        ed  = 64'd0;
        if (q.size() > 0 && q[0].e + MUL_LAT == cyc) begin
            erv = 4'(1 << q[0].id);
            eid = 2'(q[0].id);
            ed  = q[0].d;
        end
        chk("req_ready", bus.req_ready, er);
        chk("rsp_valid", bus.rsp_valid, erv);
        chk("rsp_id", bus.rsp_id, eid);
        if (erv != 4'b0000) chk("rsp_data", bus.rsp_data, ed);
        chk("busy", bus.busy, q.size() > 0);
        chk("mul_a", bus.mul_a, exp_ma);
        chk("mul_b", bus.mul_b, exp_mb);
    endtask

    task automatic drive(input logic [3:0] vld, input logic fl);
        @(negedge clk);
        bus.req_valid = vld;
        flush         = fl;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[32*i +: 32] = opa[i];
            bus.req_b[32*i +: 32] = opb[i];
        end
        #1;
        model_check();
    endtask

    task automatic tick(output int g);
        @(posedge clk);
        cyc++;
        g = model_grant(bus.req_valid);
        if (flush && !reset) q.delete();
        if (g >= 0) begin
            q.push_back('{cyc, g, {32'd0, opa[g]} * {32'd0, opb[g]}});
            exp_ma = opa[g];
            exp_mb = opb[g];
            mp     = (g + 1) % 4;
            opa[g] = rnd32();
            opb[g] = rnd32();
        end
    endtask

    vec_t       tbl [11];
    int         g;
    logic [3:0] pend;

    initial begin
        n_chk = 0; n_err = 0; mp = 0; cyc = 0;
        exp_ma = 32'd0; exp_mb = 32'd0;
        reset = 1'b0; flush = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < 4; i++) begin opa[i] = rnd32(); opb[i] = rnd32(); end
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", bus.req_ready, 4'b0000);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mul_a", bus.mul_a, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tbl[i].vld = 4'b1111;
`ifdef MULT_ARB_FIXED_PRIO_EN
            tbl[i].exp_rdy = 4'b0001;
`else
            tbl[i].exp_rdy = 4'(1 << (i % 4));
`endif
        end
        tbl[8] = '{4'b0100, 4'b0100};
`ifdef MULT_ARB_FIXED_PRIO_EN
        tbl[9]  = '{4'b1001, 4'b0001};
        tbl[10] = '{4'b1001, 4'b0001};
`else
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b0001, 4'b0001};
`endif
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].vld, 1'b0);
            chk("tbl_ready", bus.req_ready, tbl[i].exp_rdy);
            tick(g);
        end
        repeat (4) begin drive(4'b0000, 1'b0); tick(g); end

        // Single request from requester 1.
        opa[1] = 32'h0000_FFFF; opb[1] = 32'h0001_0001;
        drive(4'b0010, 1'b0); chk("single_ready", bus.req_ready, 4'b0010); tick(g);
        drive(4'b0000, 1'b0); chk("single_busy", bus.busy, 1'b1); tick(g);
        drive(4'b0000, 1'b0); tick(g);
        drive(4'b0000, 1'b0);
        chk("single_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("single_rsp_id", bus.rsp_id, 2'd1);
        chk("single_rsp_data", bus.rsp_data, 64'h0000_0000_FFFF_FFFF);
        tick(g);
        drive(4'b0000, 1'b0); chk("single_busy_end", bus.busy, 1'b0); tick(g);

        // Max operands through requester 2.
        opa[2] = 32'hFFFF_FFFF; opb[2] = 32'hFFFF_FFFF;
        drive(4'b0100, 1'b0); tick(g);
        repeat (2) begin drive(4'b0000, 1'b0); tick(g); end
        drive(4'b0000, 1'b0);
        chk("max_rsp_data", bus.rsp_data, 64'hFFFF_FFFE_0000_0001);
        tick(g);

        // Flush kills two in-flight ops and blocks a simultaneous request.
        drive(4'b0001, 1'b0); tick(g);
        drive(4'b0010, 1'b0); tick(g);
        drive(4'b0100, 1'b1); chk("flush_ready", bus.req_ready, 4'b0000); tick(g);
        drive(4'b0100, 1'b0);
        chk("flush_rsp0", bus.rsp_valid, 4'b0000);
        chk("post_flush_ready", bus.req_ready, 4'b0100);
        tick(g);
        drive(4'b0000, 1'b0); chk("flush_rsp1", bus.rsp_valid, 4'b0000); tick(g);
        repeat (3) begin drive(4'b0000, 1'b0); tick(g); end

        // Asynchronous reset with two operations in flight.
        drive(4'b1000, 1'b0); tick(g);
        drive(4'b0001, 1'b0); tick(g);
        drive(4'b0000, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("amid_ready", bus.req_ready, 4'b0000);
        chk("amid_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("amid_rsp_id", bus.rsp_id, 2'd0);
        chk("amid_busy", bus.busy, 1'b0);
        chk("amid_mul_a", bus.mul_a, 32'd0);
        chk("amid_mul_b", bus.mul_b, 32'd0);
        q.delete(); mp = 0; exp_ma = 32'd0; exp_mb = 32'd0;
        tick(g);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1111, 1'b0); chk("post_rst_ready", bus.req_ready, 4'b0001); tick(g);
        repeat (4) begin drive(4'b0000, 1'b0); tick(g); end

        // Randomized traffic with occasional flush.
        pend = 4'b0000;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) if (!pend[i]) pend[i] = 1'($urandom_range(0, 1));
            drive(pend, ($urandom_range(0, 15) == 0));
            tick(g);
            if (g >= 0) pend[g] = 1'b0;
        end
        repeat (5) begin drive(4'b0000, 1'b0); tick(g); end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one pipelined 32x32->64 multiplier (2 register stages, one product per clock) among N requesters, e.g. NTT butterfly lanes and modular-reduction units. It round-robin arbitrates per-cycle valid/ready requests, registers the operands into the multiplier and tracks requester IDs through a tag pipeline matched to the multiplier latency. Each result is routed back as a one-cycle response pulse to the requester that issued it. It sits between the butterfly datapath and the multiplier instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width, equals clog2(N_REQ)
MUL_LAT, 2, multiplier latency in clocks from operand register to registered result

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous; drops all in-flight operations
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester grant, combinational, one-hot or zero
req_a  input  32*N_REQ  operand A, requester i in bits [32i+31:32i]
req_b  input  32*N_REQ  operand B, same packing
mul_a  output  32  registered operand A to the multiplier
mul_b  output  32  registered operand B to the multiplier
mul_res  input  64  multiplier registered product
rsp_valid  output  N_REQ  one-hot response pulse
rsp_id  output  ID_W  ID of the current response
rsp_data  output  64  product, equals mul_res while any rsp_valid is high
busy  output  1  any operation in flight

Behaviour:
- Reset (async, active-high) clears the following to 0: mul_a, mul_b, every tag valid, and the round-robin pointer. With reset high, req_ready, rsp_valid, rsp_id and busy are all 0.
- Arbitration:
  - Search starts at pointer P and wraps modulo N_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - All ready bits are 0 if no requester is valid, if flush=1, or if reset=1.
  - A transfer happens at a clock edge with req_valid[i] and req_ready[i] both high.
  - On a transfer: mul_a and mul_b load req_a[i] and req_b[i], and P becomes (i+1) mod N_REQ.
  - With no transfer, mul_a, mul_b and P hold.
- Requester rules:
  - A requester must hold valid and operands stable until its transfer.
  - Ready may depend on valid.
  - One transfer at most per cycle.
- Tag pipeline:
  - Depth MUL_LAT+1, stages t0..tMUL_LAT, each holding {valid, id}.
  - t0 loads {transfer, i} every edge. Stage k loads stage k-1.
- Response:
  - rsp_valid is the one-hot decode of the final stage's id, gated by its valid. rsp_id is that id. rsp_data = mul_res.
  - rsp_valid is all zero when the final stage is invalid. rsp_data is don't-care, and rsp_id is 0 in that case.
  - No response backpressure: the requester must accept in the cycle the pulse appears.
- Latency: a transfer at edge E0 produces its response during the cycle after edge E0+MUL_LAT, i.e. 3 cycles after the request cycle for default MUL_LAT.
- Throughput: one accepted request per cycle. Responses return in acceptance order.
- flush:
  - Clears every tag valid at the next edge.
  - Blocks grants in the same cycle.
  - Operations in flight produce no response. mul_a, mul_b and P are unchanged.
  - Flush overrides a simultaneous request.
- busy = OR of all tag valids.
- Reset mid-operation: in-flight results are discarded and no rsp_valid pulse appears after reset.

Optional Feature:
MULT_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. Requester 0 can starve the others. The pointer register is not built.
- Undefined (default): round robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single request: req_valid=4'b0010, a=0x0000FFFF, b=0x00010001 at edge E0 -> rsp_valid=4'b0010, rsp_id=1, rsp_data=0x00000000FFFFFFFF in the cycle after E2. busy is high from after E0 until after E2.
- Fairness: all four valid continuously for 8 cycles after reset -> grants in order 0,1,2,3,0,1,2,3. Responses come back in the same order, 3 cycles after each grant, one per cycle. With MULT_ARB_FIXED_PRIO_EN defined -> requester 0 every cycle.
- Max operands: a=b=0xFFFFFFFF -> rsp_data=0xFFFFFFFE00000001.
- Wrap: P=3 with only requesters 0 and 3 valid -> 3 is granted, then 0.
- Flush: issue 2 requests on consecutive cycles, then assert flush for 1 cycle with requester 2 valid -> requester 2 is not granted that cycle and neither earlier request yields rsp_valid. The next grant goes normally to requester 2 with correct data.
- Reset mid-stream: assert reset asynchronously (between edges) with 2 operations in flight -> all outputs are 0 immediately. After release, no stray rsp_valid and the first grant goes to requester 0.
